// File: rtl/logic_op_pipe.sv
// logic_op_pipe: two-stage pipelined bitwise logic unit on valid/ready streams.
// Each packet selects AND, OR, XOR or NAND from its first beat. A packet
// either emits one result per beat, or (accumulate mode) folds all beats into
// one result that is emitted on the beat with in_last set.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst_n      synchronous active-low reset
//   in_valid   operand beat valid            in_ready  unit accepts a beat
//   in_a/in_b  WIDTH-bit operands
//   in_op      00 AND, 01 OR, 10 XOR, 11 NAND (first beat of packet only)
//   in_acc     accumulate packet (first beat of packet only)
//   in_last    final beat of an accumulate packet
//   out_valid  result valid                  out_ready downstream accepts
//   out_data   result                        out_count beats folded (saturating)
//   out_zero   out_data == 0
module logic_op_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  input  logic             in_acc,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_zero
);

  typedef enum logic {IDLE, ACCUM} pkt_state_t;

  function automatic logic op_bit(input logic [1:0] op, input logic x, input logic y);
    case (op)
      2'b00:   op_bit = x & y;
      2'b01:   op_bit = x | y;
      2'b10:   op_bit = x ^ y;
      default: op_bit = ~(x & y);
    endcase
  endfunction

  // Packet tracking happens at the input side so that each beat enters S1
  // already tagged with its effective op, mode and first-beat flag.
  pkt_state_t state_reg, state_next;
  logic [1:0] pkt_op_reg;
  logic       beat_first;
  logic [1:0] beat_op;
  logic       beat_acc;
  logic       accept;

  logic             s1_valid_reg;
  logic [WIDTH-1:0] s1_a_reg, s1_b_reg;
  logic [1:0]       s1_op_reg;
  logic             s1_acc_reg, s1_last_reg, s1_first_reg;
  logic             s1_emit, s1_advance;

  logic [WIDTH-1:0] acc_reg;
  logic [CNT_W-1:0] count_reg;
  logic [WIDTH-1:0] r_val, fold_val, acc_next, res_data;
  logic [CNT_W-1:0] count_next, res_count;

  logic             out_valid_reg;
  logic [WIDTH-1:0] out_data_reg;
  logic [CNT_W-1:0] out_count_reg;
  logic             out_zero_reg;

  assign accept   = in_valid & in_ready;
  assign in_ready = rst_n & (!s1_valid_reg | s1_advance);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      pkt_op_reg <= 2'b00;
    end else begin
      state_reg <= state_next;
      if (accept && state_reg == IDLE) pkt_op_reg <= in_op;
    end
  end

  always_comb begin
    state_next = state_reg;
    beat_first = 1'b0;
    beat_op    = pkt_op_reg;
    beat_acc   = 1'b1;
    case (state_reg)
      IDLE: begin
        beat_first = 1'b1;
        beat_op    = in_op;
        beat_acc   = in_acc;
        if (accept && in_acc && !in_last) state_next = ACCUM;
      end
      ACCUM: begin
        if (accept && in_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Stage 1 register. Accept and advance may coincide; accept wins the valid bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_a_reg     <= '0;
      s1_b_reg     <= '0;
      s1_op_reg    <= 2'b00;
      s1_acc_reg   <= 1'b0;
      s1_last_reg  <= 1'b0;
      s1_first_reg <= 1'b0;
    end else if (accept) begin
      s1_valid_reg <= 1'b1;
      s1_a_reg     <= in_a;
      s1_b_reg     <= in_b;
      s1_op_reg    <= beat_op;
      s1_acc_reg   <= beat_acc;
      s1_last_reg  <= in_last;
      s1_first_reg <= beat_first;
    end else if (s1_advance) begin
      s1_valid_reg <= 1'b0;
    end
  end

  // Only beats that produce a result need a free output slot.
  assign s1_emit    = !s1_acc_reg | s1_last_reg;
  assign s1_advance = s1_valid_reg & (!s1_emit | !out_valid_reg | out_ready);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign r_val[gi]    = op_bit(s1_op_reg, s1_a_reg[gi], s1_b_reg[gi]);
      assign fold_val[gi] = op_bit(s1_op_reg, acc_reg[gi], r_val[gi]);
    end
  endgenerate

  always_comb begin
    acc_next   = s1_first_reg ? r_val : fold_val;
    count_next = count_reg;
    if (s1_first_reg)     count_next = CNT_W'(1);
    else if (!(&count_reg)) count_next = count_reg + CNT_W'(1);
    res_data  = s1_acc_reg ? acc_next   : r_val;
    res_count = s1_acc_reg ? count_next : CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_reg   <= '0;
      count_reg <= '0;
    end else if (s1_advance && s1_acc_reg) begin
      acc_reg   <= acc_next;
      count_reg <= count_next;
    end
  end

  // Output register: a drain and a load in the same cycle keep one result/cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_count_reg <= '0;
      out_zero_reg  <= 1'b1;
    end else if (s1_advance && s1_emit) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= res_data;
      out_count_reg <= res_count;
      out_zero_reg  <= (res_data == '0);
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_count = out_count_reg;
  assign out_zero  = out_zero_reg;

endmodule

// File: tb/tb_logic_op_pipe.sv
// Scoreboard bench for logic_op_pipe (WIDTH=8, CNT_W=2). The driver pushes
// hand-computed results into a queue as it issues emitting beats; a monitor
// pops and compares on every output handshake and checks hold stability
// while the output is stalled.
module tb_logic_op_pipe;
  localparam int WIDTH = 8;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0, in_b = '0;
  logic [1:0]       in_op = 2'b00;
  logic             in_acc = 1'b0, in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] out_count;
  logic             out_zero;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [CNT_W-1:0] cnt;
    logic             zero;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  logic_op_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_acc(in_acc), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_count(out_count), .out_zero(out_zero)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end else begin
      $display("ok   %s = %0h", name, got);
    end
  endtask

  task automatic expect_out(input logic [WIDTH-1:0] d, input logic [CNT_W-1:0] c);
    exp_t e;
    e.data = d;
    e.cnt  = c;
    e.zero = (d == '0);
    exp_q.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge after the beat was accepted.
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic [1:0] op, input logic acc, input logic last,
                      output int stalls);
    in_valid = 1'b1; in_a = a; in_b = b; in_op = op; in_acc = acc; in_last = last;
    stalls = 0;
    #1;
    while (!in_ready && stalls < 50) begin
      @(negedge clk); #1;
      stalls++;
    end
    if (stalls >= 50) begin
      checks++; errors++;
      $display("FAIL send_timeout a=%0h b=%0h", a, b);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_%s pending=%0d", name, exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // Monitor: samples well after the negedge so driver updates have settled
  // and the values seen are those present at the next rising edge.
  initial begin
    logic             stall_prev = 1'b0;
    exp_t             snap;
    exp_t             got;
    exp_t             e;
    forever begin
      @(negedge clk); #2;
      if (rst_n && out_valid) begin
        got = {out_data, out_count, out_zero};
        if (stall_prev) begin
          checks++;
          if (got !== snap) begin
            errors++;
            $display("FAIL hold got=%0h want=%0h", got, snap);
          end
        end
        if (out_ready) begin
          stall_prev = 1'b0;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_result got data=%0h count=%0d", out_data, out_count);
          end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
              errors++;
              $display("FAIL result got data=%0h count=%0d zero=%0b want data=%0h count=%0d zero=%0b",
                       out_data, out_count, out_zero, e.data, e.cnt, e.zero);
            end else begin
              $display("ok   result data=%0h count=%0d zero=%0b", out_data, out_count, out_zero);
            end
          end
        end else begin
          stall_prev = 1'b1;
          snap = got;
        end
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    logic [WIDTH-1:0] bp_a [6];
    logic [WIDTH-1:0] bp_b [6];
    logic [WIDTH-1:0] bp_r [6];
    int bp_st [6];
    bp_a = '{8'h81, 8'hC3, 8'hE7, 8'hFF, 8'h7E, 8'h3C};
    bp_b = '{8'hFF, 8'h0F, 8'hF0, 8'h3C, 8'h81, 8'hC3};
    bp_r = '{8'h81, 8'h03, 8'hE0, 8'h3C, 8'h00, 8'h00};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_zero", out_zero, 1);
    check("rst_in_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Non-accumulate stream, one op per beat
    expect_out(8'h05, 2'd1); send(8'hA5, 8'h0F, 2'b00, 1'b0, 1'b0, st); check("t1_stall_and", st, 0);
    expect_out(8'hAF, 2'd1); send(8'hA5, 8'h0F, 2'b01, 1'b0, 1'b0, st); check("t1_stall_or", st, 0);
    expect_out(8'hAA, 2'd1); send(8'hA5, 8'h0F, 2'b10, 1'b0, 1'b0, st); check("t1_stall_xor", st, 0);
    expect_out(8'hFA, 2'd1); send(8'hA5, 8'h0F, 2'b11, 1'b0, 1'b0, st); check("t1_stall_nand", st, 0);
    wait_drain("t1");

    // XOR accumulate: r = FE, FD, FB -> fold F8, count 3
    send(8'hFF, 8'h01, 2'b10, 1'b1, 1'b0, st);
    send(8'hFF, 8'h02, 2'b10, 1'b1, 1'b0, st);
    expect_out(8'hF8, 2'd3);
    send(8'hFF, 8'h04, 2'b10, 1'b1, 1'b1, st);
    wait_drain("t2");

    // Reset in the middle of a 4-beat packet
    send(8'h12, 8'h34, 2'b01, 1'b1, 1'b0, st);
    send(8'h56, 8'h78, 2'b01, 1'b1, 1'b0, st);
    rst_n = 1'b0;
    @(negedge clk); #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_out_count", out_count, 0);
    check("mid_rst_out_zero", out_zero, 1);
    check("mid_rst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    @(negedge clk);
    expect_out(8'h00, 2'd1);
    send(8'h3C, 8'h3C, 2'b10, 1'b1, 1'b1, st);
    wait_drain("t5");

    // Backpressure: out_ready low for 5 cycles during a 6-beat AND stream
    fork
      begin
        out_ready = 1'b0;
        repeat (5) @(negedge clk);
        out_ready = 1'b1;
      end
      begin
        for (int i = 0; i < 6; i++) begin
          expect_out(bp_r[i], 2'd1);
          send(bp_a[i], bp_b[i], 2'b00, 1'b0, 1'b0, bp_st[i]);
        end
      end
    join
    check("bp_stall_beat1", bp_st[0], 0);
    check("bp_stall_beat2", bp_st[1], 0);
    check("bp_beat3_stalled", (bp_st[2] > 0), 1);
    wait_drain("t3");

    // Ignored op/acc on a later beat of an AND accumulate packet
    send(8'h0F, 8'hFF, 2'b00, 1'b1, 1'b0, st);
    expect_out(8'h00, 2'd2);
    send(8'hF0, 8'hFF, 2'b01, 1'b0, 1'b1, st);
    wait_drain("t4");

    // Count saturation with CNT_W=2: r = 03,04,08,10,00 -> OR fold 1F
    send(8'h01, 8'h02, 2'b01, 1'b1, 1'b0, st);
    send(8'h04, 8'h00, 2'b01, 1'b1, 1'b0, st);
    send(8'h00, 8'h08, 2'b01, 1'b1, 1'b0, st);
    send(8'h10, 8'h10, 2'b01, 1'b1, 1'b0, st);
    expect_out(8'h1F, 2'd3);
    send(8'h00, 8'h00, 2'b01, 1'b1, 1'b1, st);
    wait_drain("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
